// File: rtl/adder_tree_accum_pkg.sv
// Shared types and helpers for the adder-tree accumulator: FSM state encoding
// and the operand count left after a given number of pairwise-reduction stages.
package adder_tree_accum_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  // Operand count after s stages of ceil(n/2) reduction starting from n.
  function automatic int stage_size(input int n, input int s);
    int r;
    r = n;
    for (int i = 0; i < s; i++) begin
      r = (r + 1) / 2;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_accum_pipe.sv
// Pipelined masked adder tree: one input register stage, then DEPTH pairwise
// reduction stages, with a valid flag shifted alongside the data.
module adder_tree_pipe
  import adder_tree_accum_pkg::*;
#(
  parameter int NUM_INPUTS = 10,
  parameter int DATA_WIDTH = 16,
  parameter int SUM_WIDTH  = 28,
  parameter int SIGNED_IN  = 1,
  parameter int DEPTH      = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]            lane_mask,
  output logic [SUM_WIDTH-1:0]             sum_out,
  output logic                             sum_valid
);

  localparam int EXT = SUM_WIDTH - DATA_WIDTH;

  // Row s holds the operands after s reductions; only the first
  // stage_size(NUM_INPUTS, s) entries of each row are populated.
  logic [SUM_WIDTH-1:0] node_reg [DEPTH+1][NUM_INPUTS];
  logic [DEPTH:0]       valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= {valid_reg[DEPTH-1:0], valid_in};
    end
  end

  genvar gi, gj;

  for (gj = 0; gj < NUM_INPUTS; gj++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane;
    logic                  sign_bit;
    logic [SUM_WIDTH-1:0]  lane_ext;

    assign lane     = data_in[gj*DATA_WIDTH +: DATA_WIDTH];
    assign sign_bit = (SIGNED_IN != 0) && lane[DATA_WIDTH-1];
    assign lane_ext = {{EXT{sign_bit}}, lane};

    always_ff @(posedge clk) begin
      if (rst) begin
        node_reg[0][gj] <= '0;
      end else begin
        node_reg[0][gj] <= lane_mask[gj] ? lane_ext : '0;
      end
    end
  end

  for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
    localparam int N_PREV = stage_size(NUM_INPUTS, gi - 1);
    localparam int N_CUR  = stage_size(NUM_INPUTS, gi);

    for (gj = 0; gj < N_CUR; gj++) begin : g_node
      if (2*gj + 1 < N_PREV) begin : g_add
        always_ff @(posedge clk) begin
          if (rst) begin
            node_reg[gi][gj] <= '0;
          end else begin
            node_reg[gi][gj] <= node_reg[gi-1][2*gj] + node_reg[gi-1][2*gj+1];
          end
        end
      end else begin : g_pass
        // Odd operand out at this level rides through unchanged.
        always_ff @(posedge clk) begin
          if (rst) begin
            node_reg[gi][gj] <= '0;
          end else begin
            node_reg[gi][gj] <= node_reg[gi-1][2*gj];
          end
        end
      end
    end
  end

  assign sum_out   = node_reg[DEPTH][0];
  assign sum_valid = valid_reg[DEPTH];

endmodule

// File: rtl/adder_tree_accum.sv
// Masked adder tree feeding a windowed accumulator: sums acc_len_m1+1 valid
// tree sums and emits the total as a one-cycle valid_out pulse.
module adder_tree_accum
  import adder_tree_accum_pkg::*;
#(
  parameter int NUM_INPUTS  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_LOG2    = 8,
  parameter int SIGNED_IN   = 1,
  localparam int DEPTH      = $clog2(NUM_INPUTS),
  localparam int OUT_WIDTH  = DATA_WIDTH + DEPTH + ACC_LOG2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]            lane_mask,
  input  logic [ACC_LOG2-1:0]              acc_len_m1,
  input  logic                             clear,
  output logic [OUT_WIDTH-1:0]             data_out,
  output logic                             valid_out,
  output logic                             busy
);

  if (NUM_INPUTS < 2) begin : g_bad_num_inputs
    $error("adder_tree_accum: NUM_INPUTS must be at least 2");
  end

  logic [OUT_WIDTH-1:0] sum;
  logic                 sum_valid;

  adder_tree_pipe #(
    .NUM_INPUTS (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH),
    .SUM_WIDTH  (OUT_WIDTH),
    .SIGNED_IN  (SIGNED_IN),
    .DEPTH      (DEPTH)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .lane_mask (lane_mask),
    .sum_out   (sum),
    .sum_valid (sum_valid)
  );

  acc_state_t           state_reg, state_next;
  logic [OUT_WIDTH-1:0] acc_reg;
  logic [ACC_LOG2-1:0]  cnt_reg;
  logic [ACC_LOG2-1:0]  len_reg;
  logic [OUT_WIDTH-1:0] data_out_reg;
  logic                 valid_out_reg;
  logic                 last_sum;

  // cnt_reg counts sums beyond the first, so the window closes on the sum
  // that brings it up to the latched length.
  assign last_sum = sum_valid && ((cnt_reg + ACC_LOG2'(1)) == len_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (sum_valid && (acc_len_m1 != '0)) begin
            state_next = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (last_sum) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_reg == ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
    end else begin
      valid_out_reg <= 1'b0;
      if (clear) begin
        // Drop the open window together with any sum landing this cycle.
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (sum_valid) begin
        case (state_reg)
          ST_IDLE: begin
            if (acc_len_m1 == '0) begin
              data_out_reg  <= sum;
              valid_out_reg <= 1'b1;
            end else begin
              acc_reg <= sum;
              cnt_reg <= '0;
              len_reg <= acc_len_m1;
            end
          end
          ST_ACCUM: begin
            if (last_sum) begin
              data_out_reg  <= acc_reg + sum;
              valid_out_reg <= 1'b1;
              acc_reg       <= '0;
              cnt_reg       <= '0;
            end else begin
              acc_reg <= acc_reg + sum;
              cnt_reg <= cnt_reg + ACC_LOG2'(1);
            end
          end
          default: begin
            acc_reg <= '0;
            cnt_reg <= '0;
          end
        endcase
      end
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;

endmodule

// File: doc/adder_tree_accum.md
ADDER_TREE_ACCUM -- requirements
Module: adder_tree_accum

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 10, meaning the number of input lanes, legal range 2..64.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the bits per lane.
REQ-003 The block SHALL have parameter ACC_LOG2, default 8, meaning the maximum window of 2^ACC_LOG2 tree sums.
REQ-004 The block SHALL have parameter SIGNED_IN, default 1, meaning lanes are two's complement when 1 and unsigned when 0.
REQ-005 The block SHALL derive DEPTH = $clog2(NUM_INPUTS) and OUT_WIDTH = DATA_WIDTH+DEPTH+ACC_LOG2; these are not user-overridable.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port valid_in, input, 1 bit: qualifies data_in and lane_mask.
REQ-009 The block SHALL have port data_in, input, NUM_INPUTS*DATA_WIDTH bits: lane j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port lane_mask, input, NUM_INPUTS bits: bit j=1 includes lane j, bit j=0 forces lane j to zero.
REQ-011 The block SHALL have port acc_len_m1, input, ACC_LOG2 bits: window length minus 1.
REQ-012 The block SHALL have port clear, input, 1 bit: aborts the open window.
REQ-013 The block SHALL have port data_out, output, OUT_WIDTH bits: the window sum, sign- or zero-extended per SIGNED_IN.
REQ-014 The block SHALL have port valid_out, output, 1 bit: a one-cycle pulse per completed window.
REQ-015 The block SHALL have port busy, output, 1 bit: high while a window is open.

Function
REQ-016 Stage 0 SHALL register valid_in and each lane, extended to OUT_WIDTH, with masked lanes zeroed.
REQ-017 Tree stages 1..DEPTH SHALL each halve the operand count as ceil(n/2): adjacent pairs are added, and an odd last operand passes through, one register per stage.
REQ-018 A valid flag SHALL travel with the data through every stage; a cycle with valid_in=0 SHALL contribute nothing to the window (bubble).
REQ-019 The accumulator FSM SHALL have state IDLE, with transition IDLE->ACCUM on a valid tree sum, where acc<=sum, cnt<=0 and acc_len_m1 is latched.
REQ-020 In state ACCUM, each valid tree sum SHALL do acc<=acc+sum and cnt<=cnt+1.
REQ-021 When the latched length is reached, the block SHALL drive data_out<=final sum, pulse valid_out, and transition ->IDLE.
REQ-022 If acc_len_m1=0, every valid tree sum SHALL produce an output directly from IDLE.
REQ-023 acc_len_m1 SHALL be sampled only at window start; changes mid-window SHALL have no effect until the next window.
REQ-024 Latency from the valid_in of a window's last sample to valid_out SHALL be exactly DEPTH+2 cycles, with full throughput of one sample per cycle.
REQ-025 A window ending and the next window's first sum arriving back-to-back SHALL both be honoured, with no lost sample.
REQ-026 clear=1 SHALL force IDLE and discard acc on the next edge.
REQ-027 Samples already inside the tree when clear is asserted SHALL still be accumulated into a new window after clear deasserts.
REQ-028 A tree sum arriving in the same cycle as clear SHALL be discarded.
REQ-029 data_out SHALL hold its last value between valid_out pulses.
REQ-030 OUT_WIDTH SHALL be sized so that no overflow is possible; no saturation logic is required.

Reset
REQ-031 While rst is high, the block SHALL clear all valid flags, all pipeline registers, acc, cnt, data_out=0, valid_out=0 and busy=0, and put the FSM in IDLE.
REQ-032 Reset SHALL be synchronous and active-high.
REQ-033 A reset asserted mid-window SHALL discard the window and every in-flight sample.
REQ-034 The first valid_in after rst deasserts SHALL be accepted on that edge.

Structure
REQ-035 The package adder_tree_accum_pkg SHALL hold the stage_size(n, s) function and the FSM state enum typedef.
REQ-036 The pipelined masked tree SHALL be the sub-module adder_tree_pipe, with ports clk, rst, valid_in, data_in, lane_mask, sum_out and sum_valid, instantiated once.
REQ-037 The accumulator and FSM SHALL live in adder_tree_accum.
REQ-038 NUM_INPUTS<2 SHALL cause an elaboration error.

Verification
REQ-039 Defaults, all lanes=1, mask all ones, acc_len_m1=0, one valid_in -> data_out=10, valid_out high exactly 6 cycles later, one cycle wide.
REQ-040 Defaults, all lanes=0x8000 (-32768), acc_len_m1=255, 256 consecutive valid_in -> single valid_out, data_out=-83886080.
REQ-041 SIGNED_IN=0, all lanes=0xFFFF, acc_len_m1=0 -> data_out=655350.
REQ-042 Lane j=j+1, lane_mask=0x005, acc_len_m1=3, 4 samples interleaved with random bubbles -> data_out=16, one pulse, 6 cycles after the 4th sample.
REQ-043 acc_len_m1=7, clear asserted after 3 samples, then 8 more samples -> exactly one valid_out, summing only the post-clear samples, with acc_len_m1 changed mid-window ignored.
REQ-044 rst asserted for 1 cycle mid-window with samples in flight -> no valid_out for those samples, all outputs 0, and the next window is correct.
